imm_gen_buf: RTL

//  Parametrised immediate generator with a registered, buffered output for the pipelined datapath.
//  - Decodes all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount) and sign-extends to XLEN.
//  - Results go into a DEPTH-entry FIFO, so decode (stage 1) is decoupled from execute by valid/ready.
//  - A TAG_W tag (PC or ROB index) travels with each immediate.

---
 rtl/imm_gen_pkg.sv | 23 ++
 rtl/imm_gen_buf_extract.sv | 64 ++++++
 rtl/imm_gen_buf.sv | 97 +++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate format encoding and RV opcode constants
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_gen_buf_extract.sv
// rtl/imm_gen_buf_extract.sv - combinational RV32I/RV64I immediate decode
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] imm32;
  imm_fmt_e           fmt_sel;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Every format fits in 32 signed bits; the size cast below sign-extends to XLEN.
  always_comb begin
    imm32   = '0;
    fmt_sel = FMT_NONE;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        fmt_sel = FMT_I;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm32   = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
          fmt_sel = FMT_SHAMT;
        end else begin
          imm32   = {{20{instr[31]}}, instr[31:20]};
          fmt_sel = FMT_I;
        end
      end
      OPC_STORE: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt_sel = FMT_S;
      end
      OPC_BRANCH: begin
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt_sel = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32   = {instr[31:12], 12'b0};
        fmt_sel = FMT_U;
      end
      OPC_JAL: begin
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt_sel = FMT_J;
      end
      default: begin
        imm32   = '0;
        fmt_sel = FMT_NONE;
      end
    endcase
  end

  assign imm = XLEN'(imm32);
  assign fmt = fmt_sel;

endmodule

// File: rtl/imm_gen_buf.sv
// rtl/imm_gen_buf.sv - immediate generator feeding a DEPTH-entry FIFO
// Optional IMM_GEN_ILLEGAL_EN adds a per-entry unknown-opcode flag on out_illegal.
module imm_gen_buf
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_val,
  output logic [2:0]       imm_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_EN
    logic             illegal;
`endif
  } imm_entry_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  imm_entry_t      new_entry;
  imm_entry_t      head;
  imm_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (instr),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  always_comb begin
    new_entry     = '0;
    new_entry.imm = dec_imm;
    new_entry.fmt = dec_fmt;
    new_entry.tag = in_tag;
`ifdef IMM_GEN_ILLEGAL_EN
    new_entry.illegal = (dec_fmt == FMT_NONE);
`endif
  end

  // in_ready depends only on count, so out_ready never reaches it combinationally.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign head    = mem[rd_ptr];
  assign imm_val = head.imm;
  assign imm_fmt = head.fmt;
  assign out_tag = head.tag;
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = head.illegal;
`endif

endmodule
